// File: rtl/hpi_bus_sequencer_if.sv
// Bundle of the two requester ports, the soft-reset request and the otg_hpi pins.
// The sequencer uses the slave view; the surrounding system uses the master view.
interface hpi_bus_sequencer_if;
  logic        req0_valid;
  logic        req0_write;
  logic [1:0]  req0_addr;
  logic [15:0] req0_wdata;
  logic        req0_ready;
  logic        req0_done;
  logic [15:0] req0_rdata;
  logic        req1_valid;
  logic        req1_write;
  logic [1:0]  req1_addr;
  logic [15:0] req1_wdata;
  logic        req1_ready;
  logic        req1_done;
  logic [15:0] req1_rdata;
  logic        soft_reset_req;
  logic [1:0]  hpi_address;
  logic        hpi_cs_n;
  logic        hpi_r_n;
  logic        hpi_w_n;
  logic [15:0] hpi_data_out;
  logic        hpi_data_oe;
  logic [15:0] hpi_data_in;
  logic        hpi_reset_n;
  logic        busy;

  modport slave (
    input  req0_valid, req0_write, req0_addr, req0_wdata,
    input  req1_valid, req1_write, req1_addr, req1_wdata,
    input  soft_reset_req, hpi_data_in,
    output req0_ready, req0_done, req0_rdata,
    output req1_ready, req1_done, req1_rdata,
    output hpi_address, hpi_cs_n, hpi_r_n, hpi_w_n,
    output hpi_data_out, hpi_data_oe, hpi_reset_n, busy
  );

  modport master (
    output req0_valid, req0_write, req0_addr, req0_wdata,
    output req1_valid, req1_write, req1_addr, req1_wdata,
    output soft_reset_req, hpi_data_in,
    input  req0_ready, req0_done, req0_rdata,
    input  req1_ready, req1_done, req1_rdata,
    input  hpi_address, hpi_cs_n, hpi_r_n, hpi_w_n,
    input  hpi_data_out, hpi_data_oe, hpi_reset_n, busy
  );
endinterface

// File: rtl/hpi_bus_sequencer.sv
// Shares the CY7C67200 HPI port between two requesters with round-robin arbitration
// and generates registered cs/r/w/reset strobes with parameterised phase timing.
module hpi_bus_sequencer #(
  parameter int SETUP_CYCLES    = 2,
  parameter int STROBE_CYCLES   = 4,
  parameter int HOLD_CYCLES     = 2,
  parameter int RECOVERY_CYCLES = 6,
  parameter int RESET_CYCLES    = 16
) (
  input logic                clk_clk,
  input logic                reset_reset_n,
  hpi_bus_sequencer_if.slave bus
);

  typedef enum logic [2:0] {RESET_HOLD, IDLE, SETUP, STROBE, HOLD, RECOVER} state_t;

  state_t      state, next_state;
  logic [7:0]  cnt, next_cnt;
  logic        pending, next_pending;
  logic        last_served, next_last_served;
  logic        acc_write, next_acc_write;
  logic        owner, next_owner;
  logic [1:0]  acc_addr, next_acc_addr;
  logic [15:0] acc_wdata, next_acc_wdata;
  logic        grant1, idle_open, accept, complete, in_access;
  logic        next_cs_n, next_r_n, next_w_n, next_oe, next_reset_n, next_busy;
  logic        cs_n_q, r_n_q, w_n_q, oe_q, reset_n_q, busy_q, done0_q, done1_q;
  logic [15:0] rdata0_q, rdata1_q;

  // On a tie the requester that was not served last wins.
  always_comb begin
    idle_open = (state == IDLE) && !pending;
    if (bus.req0_valid && bus.req1_valid) grant1 = !last_served;
    else                                  grant1 = bus.req1_valid;
  end

  assign bus.req0_ready = idle_open && bus.req0_valid && !grant1;
  assign bus.req1_ready = idle_open && bus.req1_valid && grant1;
  assign accept         = bus.req0_ready || bus.req1_ready;

  always_comb begin
    next_state       = state;
    next_cnt         = cnt - 8'd1;
    next_pending     = pending || bus.soft_reset_req;
    next_last_served = last_served;
    next_acc_write   = acc_write;
    next_acc_addr    = acc_addr;
    next_acc_wdata   = acc_wdata;
    next_owner       = owner;
    complete         = 1'b0;
    case (state)
      RESET_HOLD: if (cnt == 8'd1) next_state = IDLE;
      IDLE: begin
        next_cnt = cnt;
        if (pending) begin
          next_state = RESET_HOLD;
          next_cnt   = 8'(RESET_CYCLES);
        end else if (accept) begin
          next_state       = SETUP;
          next_cnt         = 8'(SETUP_CYCLES);
          next_owner       = grant1;
          next_last_served = grant1;
          next_acc_write   = grant1 ? bus.req1_write : bus.req0_write;
          next_acc_addr    = grant1 ? bus.req1_addr  : bus.req0_addr;
          next_acc_wdata   = grant1 ? bus.req1_wdata : bus.req0_wdata;
        end
      end
      SETUP: if (cnt == 8'd1) begin
        next_state = STROBE;
        next_cnt   = 8'(STROBE_CYCLES);
      end
      STROBE: if (cnt == 8'd1) begin
        next_state = HOLD;
        next_cnt   = 8'(HOLD_CYCLES);
        complete   = 1'b1;
      end
      HOLD: if (cnt == 8'd1) begin
        next_state = RECOVER;
        next_cnt   = 8'(RECOVERY_CYCLES);
      end
      RECOVER: if (cnt == 8'd1) next_state = IDLE;
      default: begin
        next_state = RESET_HOLD;
        next_cnt   = 8'(RESET_CYCLES);
      end
    endcase
    if (next_state == RESET_HOLD && state != RESET_HOLD) next_pending = 1'b0;

    // Pin values are derived from the state being entered so they line up with it.
    in_access    = (next_state == SETUP) || (next_state == STROBE) || (next_state == HOLD);
    next_cs_n    = !in_access;
    next_oe      = in_access && next_acc_write;
    next_r_n     = !((next_state == STROBE) && !next_acc_write);
    next_w_n     = !((next_state == STROBE) && next_acc_write);
    next_reset_n = (next_state != RESET_HOLD);
    next_busy    = (next_state != IDLE);
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state       <= RESET_HOLD;
      cnt         <= 8'(RESET_CYCLES);
      pending     <= 1'b0;
      last_served <= 1'b1;
      acc_write   <= 1'b0;
      acc_addr    <= '0;
      acc_wdata   <= '0;
      owner       <= 1'b0;
      cs_n_q      <= 1'b1;
      r_n_q       <= 1'b1;
      w_n_q       <= 1'b1;
      oe_q        <= 1'b0;
      reset_n_q   <= 1'b0;
      busy_q      <= 1'b1;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      state       <= next_state;
      cnt         <= next_cnt;
      pending     <= next_pending;
      last_served <= next_last_served;
      acc_write   <= next_acc_write;
      acc_addr    <= next_acc_addr;
      acc_wdata   <= next_acc_wdata;
      owner       <= next_owner;
      cs_n_q      <= next_cs_n;
      r_n_q       <= next_r_n;
      w_n_q       <= next_w_n;
      oe_q        <= next_oe;
      reset_n_q   <= next_reset_n;
      busy_q      <= next_busy;
      done0_q     <= complete && !owner;
      done1_q     <= complete && owner;
      if (complete && !acc_write && !owner) rdata0_q <= bus.hpi_data_in;
      if (complete && !acc_write && owner)  rdata1_q <= bus.hpi_data_in;
    end
  end

  assign bus.hpi_address  = acc_addr;
  assign bus.hpi_data_out = acc_wdata;
  assign bus.hpi_cs_n     = cs_n_q;
  assign bus.hpi_r_n      = r_n_q;
  assign bus.hpi_w_n      = w_n_q;
  assign bus.hpi_data_oe  = oe_q;
  assign bus.hpi_reset_n  = reset_n_q;
  assign bus.busy         = busy_q;
  assign bus.req0_done    = done0_q;
  assign bus.req1_done    = done1_q;
  assign bus.req0_rdata   = rdata0_q;
  assign bus.req1_rdata   = rdata1_q;

endmodule

// File: tb/tb_hpi_bus_sequencer.sv
// Bench for hpi_bus_sequencer: directed scenarios plus random traffic, all compared
// cycle by cycle against a timeline model of accesses and reset pulses.
module tb_hpi_bus_sequencer;
  localparam int S       = 2;
  localparam int ST      = 4;
  localparam int H       = 2;
  localparam int R       = 6;
  localparam int RC      = 16;
  localparam int ACC_LEN = 1 + S + ST + H + R;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hpi_bus_sequencer_if bus ();

  hpi_bus_sequencer #(
    .SETUP_CYCLES(S), .STROBE_CYCLES(ST), .HOLD_CYCLES(H),
    .RECOVERY_CYCLES(R), .RESET_CYCLES(RC)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .bus           (bus)
  );

  int pass_count = 0;
  int check_count = 0;
  int cyc;

  // Reference timeline: when the port is free, when reset is low, and the access in flight.
  int          rst_lo, rst_hi, free_at, acc_t;
  bit          have_acc, pend, last, acc_w, owner;
  logic [1:0]  acc_a;
  logic [15:0] acc_d, cap_pad, exp_rd0, exp_rd1;

  int n_cs_low, n_r_low, n_w_low, n_oe, n_done0, n_done1, n_rst_low, n_rdy, done0_cyc;
  bit acc0_seen, acc1_seen;
  int acc_cyc[$];
  bit acc_own[$];
  logic snap_reset_n, snap_cs_n, snap_w_n, snap_oe;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    if (obs === exp) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", tag, obs, exp, cyc);
  endtask

  task automatic applyStimulus(input bit n, input bit v, input bit w, input logic [1:0] a,
                               input logic [15:0] d);
    if (n) begin
      bus.req1_valid = v; bus.req1_write = w; bus.req1_addr = a; bus.req1_wdata = d;
    end else begin
      bus.req0_valid = v; bus.req0_write = w; bus.req0_addr = a; bus.req0_wdata = d;
    end
  endtask

  task automatic model_reset(input int c);
    rst_lo   = c + 1;
    rst_hi   = c + 1 + RC;
    free_at  = rst_hi;
    have_acc = 0;
    pend     = 0;
    last     = 1;
    exp_rd0  = '0;
    exp_rd1  = '0;
  endtask

  task automatic clear_counters();
    n_cs_low = 0; n_r_low = 0; n_w_low = 0; n_oe = 0;
    n_done0 = 0; n_done1 = 0; n_rst_low = 0; n_rdy = 0; done0_cyc = -1;
  endtask

  task automatic modelCycle();
    logic v0, v1, g1, idle, act, strb, rdy0, rdy1, d0, d1, in_rst;
    logic [9:0] exp_ctl, obs_ctl;
    int c;
    c      = cyc;
    v0     = bus.req0_valid;
    v1     = bus.req1_valid;
    idle   = (c >= free_at);
    in_rst = (c >= rst_lo) && (c < rst_hi);
    act    = have_acc && (c > acc_t) && (c <= acc_t + S + ST + H);
    strb   = have_acc && (c >= acc_t + S + 1) && (c <= acc_t + S + ST);
    g1     = (v0 && v1) ? !last : v1;
    rdy0   = idle && !pend && v0 && !g1;
    rdy1   = idle && !pend && v1 && g1;
    d0     = have_acc && (c == acc_t + S + ST + 1) && !owner;
    d1     = have_acc && (c == acc_t + S + ST + 1) && owner;
    if (have_acc && (c == acc_t + S + ST + 1) && !acc_w) begin
      if (owner) exp_rd1 = cap_pad;
      else       exp_rd0 = cap_pad;
    end

    exp_ctl = {!in_rst, !idle, !act, !(strb && !acc_w), !(strb && acc_w), act && acc_w,
               d0, d1, rdy0, rdy1};
    obs_ctl = {bus.hpi_reset_n, bus.busy, bus.hpi_cs_n, bus.hpi_r_n, bus.hpi_w_n,
               bus.hpi_data_oe, bus.req0_done, bus.req1_done, bus.req0_ready, bus.req1_ready};
    checkOutput("ctl", 32'(obs_ctl), 32'(exp_ctl));
    if (act) checkOutput("addr", 32'(bus.hpi_address), 32'(acc_a));
    if (act && acc_w) checkOutput("dout", 32'(bus.hpi_data_out), 32'(acc_d));
    checkOutput("rdata0", 32'(bus.req0_rdata), 32'(exp_rd0));
    checkOutput("rdata1", 32'(bus.req1_rdata), 32'(exp_rd1));

    if (!bus.hpi_cs_n) n_cs_low++;
    if (!bus.hpi_r_n) n_r_low++;
    if (!bus.hpi_w_n) n_w_low++;
    if (bus.hpi_data_oe) n_oe++;
    if (bus.req0_done) begin n_done0++; done0_cyc = c; end
    if (bus.req1_done) n_done1++;
    if (!bus.hpi_reset_n) n_rst_low++;
    if (bus.req0_ready || bus.req1_ready) n_rdy++;
    snap_reset_n = bus.hpi_reset_n; snap_cs_n = bus.hpi_cs_n;
    snap_w_n = bus.hpi_w_n; snap_oe = bus.hpi_data_oe;

    if (rst_n && bus.req0_ready && v0) begin
      acc0_seen = 1; acc_cyc.push_back(c); acc_own.push_back(1'b0);
    end
    if (rst_n && bus.req1_ready && v1) begin
      acc1_seen = 1; acc_cyc.push_back(c); acc_own.push_back(1'b1);
    end

    if (have_acc && (c == acc_t + S + ST)) cap_pad = bus.hpi_data_in;

    if (!rst_n) model_reset(c);
    else begin
      if (idle && pend) begin
        rst_lo = c + 1; rst_hi = c + 1 + RC; free_at = rst_hi; pend = 0;
      end else if (rdy0 || rdy1) begin
        have_acc = 1; acc_t = c; owner = rdy1; last = rdy1;
        acc_w    = rdy1 ? bus.req1_write : bus.req0_write;
        acc_a    = rdy1 ? bus.req1_addr  : bus.req0_addr;
        acc_d    = rdy1 ? bus.req1_wdata : bus.req0_wdata;
        free_at  = c + ACC_LEN;
      end
      if (bus.soft_reset_req) pend = 1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    modelCycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_accept(input bit n, input int budget);
    int k;
    k = 0;
    acc0_seen = 0; acc1_seen = 0;
    while (!(n ? acc1_seen : acc0_seen) && k < budget) begin tick(); k++; end
    checkOutput("accept_seen", 32'(n ? acc1_seen : acc0_seen), 32'd1);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (cyc < free_at && k < 200) begin tick(); k++; end
    checkOutput("idle_reached", 32'(cyc >= free_at), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 2'd0, 16'h0);
    applyStimulus(1, 0, 0, 2'd0, 16'h0);
    bus.soft_reset_req = 1'b0;
    bus.hpi_data_in = 16'h0;
    model_reset(-1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;

    // Power-up followed by a requester-0 write.
    applyStimulus(0, 1, 1, 2'd2, 16'hBEEF);
    clear_counters();
    wait_accept(0, 40);
    checkOutput("pwr_accept_cycle", 32'(acc_cyc[$]), 32'(RC));
    checkOutput("pwr_reset_len", 32'(n_rst_low), 32'(RC));
    applyStimulus(0, 0, 0, 2'($urandom), 16'($urandom));
    clear_counters();
    run(ACC_LEN - 1);
    checkOutput("wr_cs_len", 32'(n_cs_low), 32'(S + ST + H));
    checkOutput("wr_w_len", 32'(n_w_low), 32'(ST));
    checkOutput("wr_r_len", 32'(n_r_low), 32'd0);
    checkOutput("wr_oe_len", 32'(n_oe), 32'(S + ST + H));
    checkOutput("wr_done0_cnt", 32'(n_done0), 32'd1);
    checkOutput("wr_done0_cycle", 32'(done0_cyc), 32'(RC + S + ST + 1));

    // Requester-1 read with a fixed pad value.
    bus.hpi_data_in = 16'h1234;
    applyStimulus(1, 1, 0, 2'd1, 16'($urandom));
    clear_counters();
    wait_accept(1, 20);
    applyStimulus(1, 0, 0, 2'($urandom), 16'($urandom));
    run(ACC_LEN - 1);
    checkOutput("rd_r_len", 32'(n_r_low), 32'(ST));
    checkOutput("rd_w_len", 32'(n_w_low), 32'd0);
    checkOutput("rd_oe_len", 32'(n_oe), 32'd0);
    checkOutput("rd_done1_cnt", 32'(n_done1), 32'd1);
    checkOutput("rd_done0_cnt", 32'(n_done0), 32'd0);
    checkOutput("rd_rdata1", 32'(bus.req1_rdata), 32'h1234);

    // Arbitration after a fresh reset with both requesters always valid.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    applyStimulus(0, 1, $urandom_range(1), 2'($urandom), 16'($urandom));
    applyStimulus(1, 1, $urandom_range(1), 2'($urandom), 16'($urandom));
    acc_cyc.delete();
    acc_own.delete();
    for (int k = 0; k < 150 && acc_cyc.size() < 5; k++) begin
      acc0_seen = 0; acc1_seen = 0;
      tick();
      if (acc0_seen) applyStimulus(0, 1, $urandom_range(1), 2'($urandom), 16'($urandom));
      if (acc1_seen) applyStimulus(1, 1, $urandom_range(1), 2'($urandom), 16'($urandom));
    end
    checkOutput("arb_count", 32'(acc_cyc.size()), 32'd5);
    for (int i = 0; i < acc_cyc.size(); i++) begin
      checkOutput("arb_owner", 32'(acc_own[i]), 32'(i % 2));
      if (i > 0) checkOutput("arb_gap", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'(ACC_LEN));
    end
    applyStimulus(0, 0, 0, 2'd0, 16'h0);
    applyStimulus(1, 0, 0, 2'd0, 16'h0);
    wait_idle();

    // Soft reset requested in the middle of a strobe.
    applyStimulus(0, 1, 1, 2'($urandom), 16'($urandom));
    wait_accept(0, 20);
    applyStimulus(0, 0, 0, 2'd0, 16'h0);
    applyStimulus(1, 1, 0, 2'($urandom), 16'($urandom));
    run(2);
    bus.soft_reset_req = 1'b1;
    clear_counters();
    tick();
    bus.soft_reset_req = 1'b0;
    run(ACC_LEN + RC - 3);
    checkOutput("sr_ready_cnt", 32'(n_rdy), 32'd0);
    checkOutput("sr_reset_len", 32'(n_rst_low), 32'(RC));
    checkOutput("sr_done0_cnt", 32'(n_done0), 32'd1);
    checkOutput("sr_w_len", 32'(n_w_low), 32'(ST));
    wait_accept(1, 5);
    applyStimulus(1, 0, 0, 2'd0, 16'h0);
    wait_idle();

    // Hard reset asserted on the second strobe cycle of a write.
    applyStimulus(0, 1, 1, 2'($urandom), 16'($urandom));
    wait_accept(0, 20);
    applyStimulus(0, 0, 0, 2'd0, 16'h0);
    run(3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    clear_counters();
    tick();
    checkOutput("mr_pins", {28'd0, snap_reset_n, snap_cs_n, snap_w_n, snap_oe}, 32'b0110);
    run(RC);
    checkOutput("mr_done0_cnt", 32'(n_done0), 32'd0);
    wait_idle();

    // Random traffic; payload is scrambled after each accept.
    for (int k = 0; k < 800; k++) begin
      if (acc0_seen || !bus.req0_valid) begin
        if ($urandom_range(3) == 0)
          applyStimulus(0, 1, $urandom_range(1), 2'($urandom), 16'($urandom));
        else
          applyStimulus(0, 0, $urandom_range(1), 2'($urandom), 16'($urandom));
      end
      if (acc1_seen || !bus.req1_valid) begin
        if ($urandom_range(3) == 0)
          applyStimulus(1, 1, $urandom_range(1), 2'($urandom), 16'($urandom));
        else
          applyStimulus(1, 0, $urandom_range(1), 2'($urandom), 16'($urandom));
      end
      bus.hpi_data_in = 16'($urandom);
      acc0_seen = 0; acc1_seen = 0;
      tick();
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end
endmodule
